video_boxcar_filter: RTL and testbench

- Parametrised successor to the fixed 8-tap, free-running video averaging filter that sits between the NTSC encoder output and the delta-sigma DAC.
- Generalised in data width, maximum depth and channel count.
- Adds runtime tap selection (1..2^C_DEPTH_LOG2), CK_EE qualification, a running-sum implementation, a rounding mode, flush, and a warm-up VALID flag.

---
 rtl/video_filt_pkg.sv | 22 ++
 rtl/video_boxcar_ch.sv | 68 ++++++
 rtl/video_boxcar_filter.sv | 118 +++++++++++
 tb/tb_video_boxcar_filter.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/video_filt_pkg.sv
// rtl/video_filt_pkg.sv - shared helpers, rounding modes and FSM states for the boxcar video filter
package video_filt_pkg;

    // Smallest r with 2^r >= v; clog2(1) == 0.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) begin
            r++;
        end
        return r;
    endfunction

    localparam logic ROUND_TRUNC   = 1'b0;
    localparam logic ROUND_HALF_UP = 1'b1;

    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } filt_state_e;

endpackage

// File: rtl/video_boxcar_ch.sv
// rtl/video_boxcar_ch.sv - one channel of the boxcar filter: delay line, running sum and output register
module video_boxcar_ch
    import video_filt_pkg::*;
#(
    parameter int C_DAT_W      = 10,
    parameter int C_DEPTH_LOG2 = 3,
    parameter int C_K_W        = 2
) (
    input  logic                    CK_i,
    input  logic                    XAR_i,
    input  logic                    en_i,
    input  logic                    flush_i,
    input  logic [C_DEPTH_LOG2-1:0] wp_i,
    input  logic [C_K_W-1:0]        k_i,
    input  logic                    round_i,
    input  logic [C_DAT_W-1:0]      dat_i,
    output logic [C_DAT_W-1:0]      dat_o
);

    localparam int DEPTH = 1 << C_DEPTH_LOG2;
    localparam int SUM_W = C_DAT_W + C_DEPTH_LOG2;

    logic [C_DAT_W-1:0]      mem_q [DEPTH];
    logic [SUM_W-1:0]        sum_q;
    logic [SUM_W-1:0]        sum_d;
    logic [C_DAT_W-1:0]      dat_q;
    logic [C_DAT_W-1:0]      dat_d;
    logic [C_DEPTH_LOG2-1:0] old_idx;
    logic [SUM_W-1:0]        half;
    logic [SUM_W-1:0]        rounded;

    // Running sum drops the sample N positions back; shift happens on the full-width sum.
    always_comb begin
        old_idx = wp_i - (C_DEPTH_LOG2'(1) << k_i);
        sum_d   = sum_q + SUM_W'(dat_i) - SUM_W'(mem_q[old_idx]);
        half    = '0;
        unique case (round_i)
            ROUND_HALF_UP: half = (k_i == '0) ? '0 : (SUM_W'(1) << (k_i - 1'b1));
            ROUND_TRUNC:   half = '0;
        endcase
        rounded = sum_d + half;
        dat_d   = C_DAT_W'(rounded >> k_i);
    end

    // History, sum and output advance on enabled samples; flush zeroes everything.
    always_ff @(posedge CK_i or negedge XAR_i) begin
        if (!XAR_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            sum_q <= '0;
            dat_q <= '0;
        end else if (flush_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            sum_q <= '0;
            dat_q <= '0;
        end else if (en_i) begin
            mem_q[wp_i] <= dat_i;
            sum_q       <= sum_d;
            dat_q       <= dat_d;
        end
    end

    assign dat_o = dat_q;

endmodule

// File: rtl/video_boxcar_filter.sv
// rtl/video_boxcar_filter.sv - multichannel runtime-selectable boxcar averaging filter
module video_boxcar_filter
    import video_filt_pkg::*;
#(
    parameter int C_DAT_W      = 10,
    parameter int C_DEPTH_LOG2 = 3,
    parameter int C_CH         = 1
) (
    input  logic                                CK_i,
    input  logic                                XAR_i,
    input  logic                                CK_EE_i,
    input  logic [clog2(C_DEPTH_LOG2+1)-1:0]    TAPS_LOG2s_i,
    input  logic                                ROUND_i,
    input  logic                                FLUSH_i,
    input  logic [C_CH*C_DAT_W-1:0]             DATs_i,
    output logic [C_CH*C_DAT_W-1:0]             DATs_o,
    output logic                                VALID_o
);

    localparam int K_W = clog2(C_DEPTH_LOG2 + 1);
    localparam int D   = C_DEPTH_LOG2;

    filt_state_e    state_q, state_d;
    logic [K_W-1:0] k_q, k_d, k_clamp;
    logic [D-1:0]   wp_q, wp_d;
    logic [D-1:0]   fill_q, fill_d;
    logic [D-1:0]   n_m1;
    logic           valid_q, valid_d;
    logic           flush;
    logic           en;
    logic [C_DAT_W-1:0] ch_dat [C_CH];

    // Requested tap exponent limited to the buffer depth.
    always_comb begin
        k_clamp = (TAPS_LOG2s_i > K_W'(D)) ? K_W'(D) : TAPS_LOG2s_i;
    end

    // A tap change restarts the history exactly like an explicit flush.
    assign flush = FLUSH_i || (k_clamp != k_q);
    assign en    = CK_EE_i && !flush;
    assign n_m1  = (D'(1) << k_q) - 1'b1;

    // Fill/run sequencing, pointer advance and tap register load.
    always_comb begin
        state_d = state_q;
        fill_d  = fill_q;
        wp_d    = wp_q;
        valid_d = valid_q;
        k_d     = k_q;
        if (flush) begin
            state_d = FILL;
            fill_d  = '0;
            wp_d    = '0;
            valid_d = 1'b0;
            k_d     = k_clamp;
        end else if (CK_EE_i) begin
            wp_d = wp_q + 1'b1;
            case (state_q)
                FILL: begin
                    if (fill_q == n_m1) begin
                        state_d = RUN;
                        valid_d = 1'b1;
                    end else begin
                        fill_d = fill_q + 1'b1;
                    end
                end
                RUN:     valid_d = 1'b1;
                default: state_d = FILL;
            endcase
        end
    end

    // Control state registers; the tap select tracks the input while in reset.
    always_ff @(posedge CK_i or negedge XAR_i) begin
        if (!XAR_i) begin
            state_q <= FILL;
            fill_q  <= '0;
            wp_q    <= '0;
            valid_q <= 1'b0;
            k_q     <= k_clamp;
        end else begin
            state_q <= state_d;
            fill_q  <= fill_d;
            wp_q    <= wp_d;
            valid_q <= valid_d;
            k_q     <= k_d;
        end
    end

    for (genvar c = 0; c < C_CH; c++) begin : g_ch
        video_boxcar_ch #(
            .C_DAT_W      (C_DAT_W),
            .C_DEPTH_LOG2 (C_DEPTH_LOG2),
            .C_K_W        (K_W)
        ) u_ch (
            .CK_i    (CK_i),
            .XAR_i   (XAR_i),
            .en_i    (en),
            .flush_i (flush),
            .wp_i    (wp_q),
            .k_i     (k_q),
            .round_i (ROUND_i),
            .dat_i   (DATs_i[c*C_DAT_W +: C_DAT_W]),
            .dat_o   (ch_dat[c])
        );
    end

    // Pack channel outputs LSB-first.
    always_comb begin
        DATs_o = '0;
        for (int c = 0; c < C_CH; c++) begin
            DATs_o[c*C_DAT_W +: C_DAT_W] = ch_dat[c];
        end
    end

    assign VALID_o = valid_q;

endmodule

// File: tb/tb_video_boxcar_filter.sv
// tb/tb_video_boxcar_filter.sv - self-checking bench for video_boxcar_filter
module tb_video_boxcar_filter;

    localparam int W  = 10;
    localparam int D  = 3;
    localparam int CH = 2;
    localparam int TW = 2;

    logic            CK_i = 1'b0;
    logic            XAR_i = 1'b1;
    logic            CK_EE_i = 1'b0;
    logic [TW-1:0]   TAPS_LOG2s_i = TW'(3);
    logic            ROUND_i = 1'b0;
    logic            FLUSH_i = 1'b0;
    logic [CH*W-1:0] DATs_i = '0;
    wire  [CH*W-1:0] DATs_o;
    wire             VALID_o;

    int n_chk  = 0;
    int n_fail = 0;

    int hist [CH][$];
    int mk = 3;
    int exp_dat [CH] = '{0, 0};
    bit exp_valid = 1'b0;

    video_boxcar_filter #(
        .C_DAT_W      (W),
        .C_DEPTH_LOG2 (D),
        .C_CH         (CH)
    ) dut (
        .CK_i         (CK_i),
        .XAR_i        (XAR_i),
        .CK_EE_i      (CK_EE_i),
        .TAPS_LOG2s_i (TAPS_LOG2s_i),
        .ROUND_i      (ROUND_i),
        .FLUSH_i      (FLUSH_i),
        .DATs_i       (DATs_i),
        .DATs_o       (DATs_o),
        .VALID_o      (VALID_o)
    );

    initial forever #5 CK_i = ~CK_i;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    function automatic int clampk(input int t);
        return (t > D) ? D : t;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int dat_of(input int c);
        return int'(DATs_o[c*W +: W]);
    endfunction

    // Model: average of the most recent N samples since the last clear.
    task automatic model_clear();
        mk = clampk(int'(TAPS_LOG2s_i));
        for (int c = 0; c < CH; c++) begin
            hist[c].delete();
            exp_dat[c] = 0;
        end
        exp_valid = 1'b0;
    endtask

    task automatic model_step();
        int kc;
        int n;
        int s;
        kc = clampk(int'(TAPS_LOG2s_i));
        if (FLUSH_i || kc != mk) begin
            model_clear();
        end else if (CK_EE_i) begin
            n = 1 << mk;
            for (int c = 0; c < CH; c++) begin
                hist[c].push_front(int'(DATs_i[c*W +: W]));
                if (hist[c].size() > (1 << D)) void'(hist[c].pop_back());
                s = 0;
                for (int i = 0; i < n && i < hist[c].size(); i++) s += hist[c][i];
                exp_dat[c] = (s + (ROUND_i ? n / 2 : 0)) >> mk;
            end
            exp_valid = (hist[0].size() >= n);
        end
    endtask

    always @(posedge CK_i or negedge XAR_i) begin
        if (!XAR_i) model_clear();
        else        model_step();
    end

    always @(negedge CK_i) begin
        for (int c = 0; c < CH; c++) chk($sformatf("model_dat_ch%0d", c), dat_of(c), exp_dat[c]);
        chk("model_valid", int'(VALID_o), int'(exp_valid));
    end

    task automatic cyc(input int d0, input int d1, input bit en, input bit fl = 1'b0);
        DATs_i  = {W'(d1), W'(d0)};
        CK_EE_i = en;
        FLUSH_i = fl;
        @(negedge CK_i);
    endtask

    int r_in [4]   = '{1, 1, 0, 0};
    int r_half [4] = '{0, 1, 1, 1};

    initial begin
        #1 XAR_i = 1'b0;
        repeat (3) @(negedge CK_i);
        chk("reset_ch0", dat_of(0), 0);
        chk("reset_ch1", dat_of(1), 0);
        chk("reset_valid", int'(VALID_o), 0);
        XAR_i = 1'b1;

        // k=3 fill ramp on both channels
        for (int i = 0; i < 8; i++) begin
            cyc(800, 1000, 1'b1);
            chk("ramp_ch0", dat_of(0), 100 * (i + 1));
            chk("ramp_ch1", dat_of(1), 125 * (i + 1));
            chk("ramp_valid", int'(VALID_o), int'(i == 7));
        end
        repeat (3) begin
            cyc(800, 1000, 1'b1);
            chk("steady_ch0", dat_of(0), 800);
        end

        // channel independence
        for (int i = 0; i < 8; i++) begin
            cyc(0, 1000, 1'b1);
            chk("mc_ch1", dat_of(1), 1000);
        end
        chk("mc_ch0_end", dat_of(0), 0);

        // enable low holds everything
        repeat (10) cyc(555, 3, 1'b0);
        chk("hold_ch1", dat_of(1), 1000);
        chk("hold_valid", int'(VALID_o), 1);

        // asynchronous reset mid-cycle
        #2 XAR_i = 1'b0;
        #1;
        chk("async_ch1", dat_of(1), 0);
        chk("async_valid", int'(VALID_o), 0);
        TAPS_LOG2s_i = TW'(2);
        ROUND_i = 1'b0;
        @(negedge CK_i);
        XAR_i = 1'b1;

        // k=2 truncate then round half up
        for (int i = 0; i < 4; i++) begin
            cyc(r_in[i], 3, 1'b1);
            chk("trunc_ch0", dat_of(0), 0);
        end
        chk("trunc_valid", int'(VALID_o), 1);
        cyc(5, 5, 1'b1, 1'b1);
        chk("flush_en_ch0", dat_of(0), 0);
        chk("flush_en_valid", int'(VALID_o), 0);
        ROUND_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc(r_in[i], 3, 1'b1);
            chk("round_ch0", dat_of(0), r_half[i]);
        end
        for (int i = 0; i < 4; i++) begin
            cyc(1, 3, 1'b1);
            chk("round_ones", dat_of(0), 1);
        end

        // full scale at k=3, rounding on
        TAPS_LOG2s_i = TW'(3);
        cyc(0, 0, 1'b0);
        chk("tapchg_valid", int'(VALID_o), 0);
        for (int i = 0; i < 8; i++) begin
            cyc(1023, 0, 1'b1);
            chk("fs_ramp", dat_of(0), (1023 * (i + 1) + 4) >> 3);
        end
        repeat (2) begin
            cyc(1023, 0, 1'b1);
            chk("fs_steady", dat_of(0), 1023);
        end
        ROUND_i = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cyc(0, 0, 1'b1);
            chk("fs_step", dat_of(0), (1023 * (7 - i)) >> 3);
        end
        chk("fs_step_first_pin", (1023 * 7) >> 3, 895);

        // tap change from RUN: k=3 -> k=1, flush-cycle sample discarded
        TAPS_LOG2s_i = TW'(1);
        cyc(5, 5, 1'b1);
        chk("tap1_flush_valid", int'(VALID_o), 0);
        chk("tap1_flush_ch0", dat_of(0), 0);
        cyc(10, 20, 1'b1);
        chk("tap1_s1_ch0", dat_of(0), 5);
        chk("tap1_s1_ch1", dat_of(1), 10);
        chk("tap1_s1_valid", int'(VALID_o), 0);
        cyc(20, 40, 1'b1);
        chk("tap1_s2_ch0", dat_of(0), 15);
        chk("tap1_s2_ch1", dat_of(1), 30);
        chk("tap1_s2_valid", int'(VALID_o), 1);

        // flush without enable still clears
        cyc(7, 7, 1'b0, 1'b1);
        chk("flush_noen_ch0", dat_of(0), 0);
        chk("flush_noen_valid", int'(VALID_o), 0);

        // all-ones tap select behaves as the maximum depth
        TAPS_LOG2s_i = '1;
        cyc(0, 0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            cyc(800, 0, 1'b1);
            chk("max_ch0", dat_of(0), 100 * (i + 1));
            chk("max_valid", int'(VALID_o), int'(i == 7));
        end

        // k=0: plain register, valid on first sample, rounding adds nothing
        TAPS_LOG2s_i = TW'(0);
        ROUND_i = 1'b1;
        cyc(0, 0, 1'b0);
        cyc(37, 999, 1'b1);
        chk("k0_ch0", dat_of(0), 37);
        chk("k0_ch1", dat_of(1), 999);
        chk("k0_valid", int'(VALID_o), 1);
        cyc(38, 1, 1'b1);
        chk("k0_ch0_b", dat_of(0), 38);
        chk("k0_ch1_b", dat_of(1), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
